// File: rtl/geriyaz_hakem_pkg.sv
// Shared widths, default sizing and the queued result record for the write-back arbiter.
// Everything that touches a write-back result imports this package.
package geriyaz_hakem_pkg;

    localparam int VERI_BIT         = 32;
    localparam int YAZMAC_BIT       = 5;
    localparam int UOP_TAG_BIT      = 6;
    localparam int GH_ISTEKCI       = 3;
    localparam int GH_FIFO_DERINLIK = 2;

    typedef struct packed {
        logic [VERI_BIT-1:0]    veri;
        logic [YAZMAC_BIT-1:0]  adres;
        logic [UOP_TAG_BIT-1:0] etiket;
    } kayit_t;

    // Index width that stays at least one bit wide for single-entry cases.
    function automatic int genislik(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/geriyaz_fifo.sv
// Per-requester result queue: DERINLIK entries, wrapping pointers, occupancy counter.
// Full/empty come from registered occupancy only, so a same-cycle pop never raises hazir.
module geriyaz_fifo
    import geriyaz_hakem_pkg::*;
#(
    parameter int DERINLIK = GH_FIFO_DERINLIK
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  kayit_t yaz,
    input  logic   pop,
    output kayit_t bas,
    output logic   dolu,
    output logic   bos
);

    localparam int PTR_W = genislik(DERINLIK);
    localparam int SAY_W = $clog2(DERINLIK + 1);

    kayit_t           mem [DERINLIK];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SAY_W-1:0] doluluk;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ilerle(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DERINLIK - 1)) ? '0 : p + 1'b1;
    endfunction

    assign dolu    = (doluluk == SAY_W'(DERINLIK));
    assign bos     = (doluluk == '0);
    assign push_ok = push && !dolu;
    assign pop_ok  = pop && !bos;
    assign bas     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            doluluk <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ilerle(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ilerle(rd_ptr);
            end
            // Push and pop together leave the count alone.
            if (push_ok && !pop_ok) begin
                doluluk <= doluluk + 1'b1;
            end else if (pop_ok && !push_ok) begin
                doluluk <= doluluk - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= yaz;
        end
    end

endmodule

// File: rtl/geriyaz_hakem.sv
// Write-back arbiter: one queue per result producer, round-robin grant, registered
// register-file write port. Zero-address results are drained without a write strobe.
module geriyaz_hakem
    import geriyaz_hakem_pkg::*;
#(
    parameter int ISTEKCI       = GH_ISTEKCI,
    parameter int FIFO_DERINLIK = GH_FIFO_DERINLIK
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [ISTEKCI-1:0]             istek_gecerli_i,
    output logic [ISTEKCI-1:0]             istek_hazir_o,
    input  logic [ISTEKCI*VERI_BIT-1:0]    istek_veri_i,
    input  logic [ISTEKCI*YAZMAC_BIT-1:0]  istek_adres_i,
    input  logic [ISTEKCI*UOP_TAG_BIT-1:0] istek_etiket_i,
    output logic [VERI_BIT-1:0]            geriyaz_veri_o,
    output logic [YAZMAC_BIT-1:0]          geriyaz_adres_o,
    output logic [UOP_TAG_BIT-1:0]         geriyaz_etiket_o,
    output logic                           geriyaz_gecerli_o,
    output logic                           hakem_bos_o
);

    localparam int IDX_W = genislik(ISTEKCI);

    kayit_t             bas [ISTEKCI];
    logic [ISTEKCI-1:0] dolu;
    logic [ISTEKCI-1:0] bos;
    logic [ISTEKCI-1:0] pop;
    logic [IDX_W-1:0]   son_kazanan;
    logic [IDX_W-1:0]   kazanan;
    logic               kazandi;
    kayit_t             secilen;

    for (genvar k = 0; k < ISTEKCI; k++) begin : g_kuyruk
        kayit_t yaz;

        assign yaz = {istek_veri_i[k*VERI_BIT +: VERI_BIT],
                      istek_adres_i[k*YAZMAC_BIT +: YAZMAC_BIT],
                      istek_etiket_i[k*UOP_TAG_BIT +: UOP_TAG_BIT]};
        assign pop[k]           = kazandi && (kazanan == IDX_W'(k));
        assign istek_hazir_o[k] = !dolu[k];

        geriyaz_fifo #(
            .DERINLIK (FIFO_DERINLIK)
        ) u_fifo (
            .clk  (clk_i),
            .rst  (rst_i),
            .push (istek_gecerli_i[k]),
            .yaz  (yaz),
            .pop  (pop[k]),
            .bas  (bas[k]),
            .dolu (dolu[k]),
            .bos  (bos[k])
        );
    end

    // Search starts just after the last winner, which bounds any wait to ISTEKCI-1 grants.
    always_comb begin
        int aday;
        aday    = 0;
        kazandi = 1'b0;
        kazanan = '0;
        secilen = '0;
        for (int i = 1; i <= ISTEKCI; i++) begin
            aday = (int'(son_kazanan) + i) % ISTEKCI;
            if (!kazandi && !bos[aday]) begin
                kazandi = 1'b1;
                kazanan = IDX_W'(aday);
                secilen = bas[aday];
            end
        end
    end

    // Zero-address results are popped but leave the write port untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            son_kazanan       <= IDX_W'(ISTEKCI - 1);
            geriyaz_gecerli_o <= 1'b0;
            geriyaz_veri_o    <= '0;
            geriyaz_adres_o   <= '0;
            geriyaz_etiket_o  <= '0;
        end else if (kazandi) begin
            son_kazanan       <= kazanan;
            geriyaz_gecerli_o <= (secilen.adres != '0);
            if (secilen.adres != '0) begin
                geriyaz_veri_o   <= secilen.veri;
                geriyaz_adres_o  <= secilen.adres;
                geriyaz_etiket_o <= secilen.etiket;
            end
        end else begin
            geriyaz_gecerli_o <= 1'b0;
        end
    end

    assign hakem_bos_o = (&bos) && !geriyaz_gecerli_o;

endmodule
